// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pkg
// Description : Shared constants and helpers for the multi-lane EX/MEM
//               pipeline register (kill-mask derivation, population count).
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  localparam int MEMTOREG_W = 2;
  localparam int REGDST_W   = 2;

  // Helpers operate on a fixed maximum lane count; callers zero-extend.
  localparam int MAX_LANES  = 32;
  localparam int LCNT_W     = 6;

  // A lane is killed by its own flush bit or by a redirect in any older lane.
  function automatic logic [MAX_LANES-1:0] kill_mask_f(
    input logic [MAX_LANES-1:0] flush_lane,
    input logic [MAX_LANES-1:0] branch_kill
  );
    logic [MAX_LANES-1:0] mask;
    logic                 older_redirect;
    mask           = '0;
    older_redirect = 1'b0;
    for (int j = 0; j < MAX_LANES; j++) begin
      mask[j]        = flush_lane[j] | older_redirect;
      older_redirect = older_redirect | branch_kill[j];
    end
    return mask;
  endfunction

  // Number of set bits in a lane vector.
  function automatic logic [LCNT_W-1:0] popcount_f(input logic [MAX_LANES-1:0] bits);
    logic [LCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {{(LCNT_W-1){1'b0}}, bits[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_lane_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating accumulator with synchronous clear; adds a
//               variable amount per enabled cycle and sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import ex_mem_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ADD_W = LCNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [ADD_W-1:0] add,
  output logic [CNT_W-1:0] count
);

  // One guard bit above the wider operand so the sum never overflows.
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] w_cnt_ext;
  logic [SUM_W-1:0] w_add_ext;
  logic [SUM_W-1:0] w_max_ext;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_next;

  // Widen operands and clamp the sum at the counter's maximum value.
  always_comb begin
    w_cnt_ext               = '0;
    w_cnt_ext[CNT_W-1:0]    = r_count;
    w_add_ext               = '0;
    w_add_ext[ADD_W-1:0]    = add;
    w_max_ext               = '0;
    w_max_ext[CNT_W-1:0]    = {CNT_W{1'b1}};
    w_sum                   = w_cnt_ext + w_add_ext;
    w_next                  = (w_sum > w_max_ext) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // Clear wins over any same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ex_mem_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_lane_pipe
// Description : Multi-lane EX/MEM pipeline register with per-slot valid,
//               stall, per-lane / branch-ordered kill, global flush and
//               saturating retire/kill statistics. Lane 0 is oldest.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_lane_pipe
  import ex_mem_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush_all,
  input  logic [LANES-1:0]            flush_lane,
  input  logic [LANES-1:0]            branch_kill,
  input  logic                        cnt_clr,
  input  logic [LANES-1:0]            valid_ex,
  input  logic [LANES-1:0]            mem_read_en_ex,
  input  logic [LANES-1:0]            mem_write_en_ex,
  input  logic [LANES-1:0]            reg_write_en_ex,
  input  logic [LANES*DATA_W-1:0]     alu_out_ex,
  input  logic [LANES*DATA_W-1:0]     store_data_ex,
  input  logic [LANES*REG_W-1:0]      dest_reg_ex,
  input  logic [LANES*PC_W-1:0]       pc_plus_ex,
  input  logic [LANES*MEMTOREG_W-1:0] mem_to_reg_ex,
  input  logic [LANES*REGDST_W-1:0]   reg_dst_ex,
  output logic [LANES-1:0]            valid_mem,
  output logic [LANES-1:0]            mem_read_en_mem,
  output logic [LANES-1:0]            mem_write_en_mem,
  output logic [LANES-1:0]            reg_write_en_mem,
  output logic [LANES*DATA_W-1:0]     alu_out_mem,
  output logic [LANES*DATA_W-1:0]     store_data_mem,
  output logic [LANES*REG_W-1:0]      dest_reg_mem,
  output logic [LANES*PC_W-1:0]       pc_plus_mem,
  output logic [LANES*MEMTOREG_W-1:0] mem_to_reg_mem,
  output logic [LANES*REGDST_W-1:0]   reg_dst_mem,
  output logic [CNT_W-1:0]            retired_cnt,
  output logic [CNT_W-1:0]            killed_cnt
);

  logic [MAX_LANES-1:0] w_flush_ext;
  logic [MAX_LANES-1:0] w_branch_ext;
  logic [MAX_LANES-1:0] w_valid_ext;
  logic [MAX_LANES-1:0] w_kill_full;
  logic                 w_unused_kill;
  logic [LANES-1:0]     w_kill;
  logic [LCNT_W-1:0]    w_retire_add;
  logic [LCNT_W-1:0]    w_kill_add;
  logic                 w_cnt_en;

  // Derive the kill mask and per-edge statistics increments.
  always_comb begin
    w_flush_ext              = '0;
    w_flush_ext[LANES-1:0]   = flush_lane;
    w_branch_ext             = '0;
    w_branch_ext[LANES-1:0]  = branch_kill;
    w_valid_ext              = '0;
    w_valid_ext[LANES-1:0]   = valid_ex;
    w_kill_full              = kill_mask_f(w_flush_ext, w_branch_ext);
    w_kill                   = w_kill_full[LANES-1:0];
    // Counters move on a flush or a normal load, never while stalled.
    w_cnt_en                 = flush_all | ~stall;
    if (flush_all) begin
      w_retire_add = '0;
      w_kill_add   = popcount_f(w_valid_ext);
    end else begin
      w_retire_add = popcount_f(w_valid_ext & ~w_kill_full);
      w_kill_add   = popcount_f(w_valid_ext & w_kill_full);
    end
  end

  // Upper mask bits beyond LANES are intentionally discarded.
  assign w_unused_kill = ^w_kill_full;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic                  r_valid;
    logic                  r_mem_read_en;
    logic                  r_mem_write_en;
    logic                  r_reg_write_en;
    logic [DATA_W-1:0]     r_alu_out;
    logic [DATA_W-1:0]     r_store_data;
    logic [REG_W-1:0]      r_dest_reg;
    logic [PC_W-1:0]       r_pc_plus;
    logic [MEMTOREG_W-1:0] r_mem_to_reg;
    logic [REGDST_W-1:0]   r_reg_dst;

    // Capture one issue slot, or load a bubble when flushed or killed.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_valid        <= 1'b0;
        r_mem_read_en  <= 1'b0;
        r_mem_write_en <= 1'b0;
        r_reg_write_en <= 1'b0;
        r_alu_out      <= '0;
        r_store_data   <= '0;
        r_dest_reg     <= '0;
        r_pc_plus      <= '0;
        r_mem_to_reg   <= '0;
        r_reg_dst      <= '0;
      end else if (flush_all || (!stall && w_kill[g])) begin
        r_valid        <= 1'b0;
        r_mem_read_en  <= 1'b0;
        r_mem_write_en <= 1'b0;
        r_reg_write_en <= 1'b0;
        r_alu_out      <= '0;
        r_store_data   <= '0;
        r_dest_reg     <= '0;
        r_pc_plus      <= '0;
        r_mem_to_reg   <= '0;
        r_reg_dst      <= '0;
      end else if (!stall) begin
        r_valid        <= valid_ex[g];
        r_mem_read_en  <= mem_read_en_ex[g];
        r_mem_write_en <= mem_write_en_ex[g];
        r_reg_write_en <= reg_write_en_ex[g];
        r_alu_out      <= alu_out_ex[g*DATA_W +: DATA_W];
        r_store_data   <= store_data_ex[g*DATA_W +: DATA_W];
        r_dest_reg     <= dest_reg_ex[g*REG_W +: REG_W];
        r_pc_plus      <= pc_plus_ex[g*PC_W +: PC_W];
        r_mem_to_reg   <= mem_to_reg_ex[g*MEMTOREG_W +: MEMTOREG_W];
        r_reg_dst      <= reg_dst_ex[g*REGDST_W +: REGDST_W];
      end
    end

    assign valid_mem[g]                                = r_valid;
    assign mem_read_en_mem[g]                          = r_mem_read_en;
    assign mem_write_en_mem[g]                         = r_mem_write_en;
    assign reg_write_en_mem[g]                         = r_reg_write_en;
    assign alu_out_mem[g*DATA_W +: DATA_W]             = r_alu_out;
    assign store_data_mem[g*DATA_W +: DATA_W]          = r_store_data;
    assign dest_reg_mem[g*REG_W +: REG_W]              = r_dest_reg;
    assign pc_plus_mem[g*PC_W +: PC_W]                 = r_pc_plus;
    assign mem_to_reg_mem[g*MEMTOREG_W +: MEMTOREG_W]  = r_mem_to_reg;
    assign reg_dst_mem[g*REGDST_W +: REGDST_W]         = r_reg_dst;
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .ADD_W (LCNT_W)
  ) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (w_cnt_en),
    .add   (w_retire_add),
    .count (retired_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W),
    .ADD_W (LCNT_W)
  ) u_killed_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (w_cnt_en),
    .add   (w_kill_add),
    .count (killed_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_lane_pipe
// Description : Directed scoreboard bench for ex_mem_lane_pipe (2 lanes,
//               4-bit counters so saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_lane_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall, flush_all, cnt_clr;
  logic [1:0]  flush_lane, branch_kill;
  logic [1:0]  valid_ex, mem_read_en_ex, mem_write_en_ex, reg_write_en_ex;
  logic [63:0] alu_out_ex, store_data_ex;
  logic [9:0]  dest_reg_ex;
  logic [15:0] pc_plus_ex;
  logic [3:0]  mem_to_reg_ex, reg_dst_ex;
  logic [1:0]  valid_mem, mem_read_en_mem, mem_write_en_mem, reg_write_en_mem;
  logic [63:0] alu_out_mem, store_data_mem;
  logic [9:0]  dest_reg_mem;
  logic [15:0] pc_plus_mem;
  logic [3:0]  mem_to_reg_mem, reg_dst_mem;
  logic [3:0]  retired_cnt, killed_cnt;

  typedef struct packed {
    logic [1:0]  v, mr, mw, rw;
    logic [63:0] alu, sd;
    logic [9:0]  dst;
    logic [15:0] pc;
    logic [3:0]  m2r, rd;
    logic [3:0]  ret, kil;
  } exp_t;

  exp_t e_next;
  exp_t q_exp[$];
  int   q_id[$];
  int   next_id = 1;
  int   total = 0;
  int   bad = 0;
  bit   end_req = 1'b0;
  event mid_ev;

  always #5 clk = ~clk;

  ex_mem_lane_pipe #(
    .LANES(2), .DATA_W(32), .PC_W(8), .REG_W(5), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_all(flush_all),
    .flush_lane(flush_lane), .branch_kill(branch_kill), .cnt_clr(cnt_clr),
    .valid_ex(valid_ex), .mem_read_en_ex(mem_read_en_ex),
    .mem_write_en_ex(mem_write_en_ex), .reg_write_en_ex(reg_write_en_ex),
    .alu_out_ex(alu_out_ex), .store_data_ex(store_data_ex),
    .dest_reg_ex(dest_reg_ex), .pc_plus_ex(pc_plus_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .reg_dst_ex(reg_dst_ex),
    .valid_mem(valid_mem), .mem_read_en_mem(mem_read_en_mem),
    .mem_write_en_mem(mem_write_en_mem), .reg_write_en_mem(reg_write_en_mem),
    .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
    .dest_reg_mem(dest_reg_mem), .pc_plus_mem(pc_plus_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .reg_dst_mem(reg_dst_mem),
    .retired_cnt(retired_cnt), .killed_cnt(killed_cnt)
  );

  task automatic drv_lane(input int l, input logic v, input logic mr, input logic mw,
                          input logic rw, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] dst, input logic [7:0] pc,
                          input logic [1:0] m2r, input logic [1:0] rd);
    valid_ex[l]               = v;
    mem_read_en_ex[l]         = mr;
    mem_write_en_ex[l]        = mw;
    reg_write_en_ex[l]        = rw;
    alu_out_ex[l*32 +: 32]    = alu;
    store_data_ex[l*32 +: 32] = sd;
    dest_reg_ex[l*5 +: 5]     = dst;
    pc_plus_ex[l*8 +: 8]      = pc;
    mem_to_reg_ex[l*2 +: 2]   = m2r;
    reg_dst_ex[l*2 +: 2]      = rd;
  endtask

  task automatic exp_lane(input int l, input logic v, input logic mr, input logic mw,
                          input logic rw, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] dst, input logic [7:0] pc,
                          input logic [1:0] m2r, input logic [1:0] rd);
    e_next.v[l]             = v;
    e_next.mr[l]            = mr;
    e_next.mw[l]            = mw;
    e_next.rw[l]            = rw;
    e_next.alu[l*32 +: 32]  = alu;
    e_next.sd[l*32 +: 32]   = sd;
    e_next.dst[l*5 +: 5]    = dst;
    e_next.pc[l*8 +: 8]     = pc;
    e_next.m2r[l*2 +: 2]    = m2r;
    e_next.rd[l*2 +: 2]     = rd;
  endtask

  // Lane carried through unchanged: expected equals the driven literals.
  task automatic pass_lane(input int l, input logic v, input logic mr, input logic mw,
                           input logic rw, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] dst, input logic [7:0] pc,
                           input logic [1:0] m2r, input logic [1:0] rd);
    drv_lane(l, v, mr, mw, rw, alu, sd, dst, pc, m2r, rd);
    exp_lane(l, v, mr, mw, rw, alu, sd, dst, pc, m2r, rd);
  endtask

  // Lane driven but expected squashed to a bubble (e_next already zero).
  task automatic kill_lane(input int l, input logic [31:0] alu, input logic [4:0] dst);
    drv_lane(l, 1'b1, 1'b1, 1'b1, 1'b1, alu, 32'h0BAD_0000, dst, 8'hEE, 2'd3, 2'd3);
  endtask

  task automatic start();
    @(negedge clk);
    stall = 0; flush_all = 0; cnt_clr = 0; flush_lane = '0; branch_kill = '0;
    valid_ex = '0; mem_read_en_ex = '0; mem_write_en_ex = '0; reg_write_en_ex = '0;
    alu_out_ex = '0; store_data_ex = '0; dest_reg_ex = '0; pc_plus_ex = '0;
    mem_to_reg_ex = '0; reg_dst_ex = '0;
    e_next = '0;
  endtask

  task automatic issue(input logic [3:0] ret, input logic [3:0] kil);
    e_next.ret = ret;
    e_next.kil = kil;
    @(posedge clk);
    q_exp.push_back(e_next);
    q_id.push_back(next_id);
    next_id++;
  endtask

  // Hand-computed counter trajectories for the saturation phases.
  logic [3:0] ret_sat_tab [10] = '{4'd10, 4'd12, 4'd14, 4'd15, 4'd15,
                                   4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
  logic [3:0] kil_sat_tab [6]  = '{4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd15};

  // Monitor: pop one expectation per presented output sample and compare.
  initial begin : monitor
    exp_t act, ex;
    int   id;
    forever begin
      @(negedge clk or mid_ev);
      if (end_req) begin
        total++;
        if (q_exp.size() != 0) begin
          bad++;
          $display("FAIL sb_drain: pending=%0d required=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end else if (q_exp.size() > 0) begin
        ex  = q_exp.pop_front();
        id  = q_id.pop_front();
        act = '{v: valid_mem, mr: mem_read_en_mem, mw: mem_write_en_mem,
                rw: reg_write_en_mem, alu: alu_out_mem, sd: store_data_mem,
                dst: dest_reg_mem, pc: pc_plus_mem, m2r: mem_to_reg_mem,
                rd: reg_dst_mem, ret: retired_cnt, kil: killed_cnt};
        total++;
        if (act !== ex) begin
          bad++;
          $display("FAIL step%0d: actual=%h required=%h", id, act, ex);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not reach end");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // 1: reset held low dominates driven inputs
    start();
    drv_lane(0, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1, 5'd1, 8'h1, 2'd1, 2'd1);
    issue(0, 0);

    // 2: normal dual load
    start(); reset = 1'b1;
    pass_lane(0, 1, 1, 0, 1, 32'h0000_AAAA, 32'h11, 5'd3, 8'h04, 2'd1, 2'd1);
    pass_lane(1, 1, 0, 1, 0, 32'h0000_5555, 32'h22, 5'd7, 8'h05, 2'd2, 2'd2);
    issue(2, 0);

    // 3: lane0 redirect kills younger lane1
    start(); branch_kill = 2'b01;
    pass_lane(0, 1, 0, 0, 1, 32'h100, 32'h0, 5'd4, 8'h10, 2'd0, 2'd1);
    kill_lane(1, 32'h200, 5'd5);
    issue(3, 1);

    // 4: invalid but unkilled lane passes its payload
    start();
    pass_lane(0, 1, 0, 0, 1, 32'h33, 32'h0, 5'd6, 8'h20, 2'd0, 2'd0);
    pass_lane(1, 0, 0, 0, 1, 32'h44, 32'h55, 5'd9, 8'h21, 2'd1, 2'd2);
    issue(4, 1);

    // 5-7: stall holds everything while kill inputs toggle
    for (int k = 0; k < 3; k++) begin
      start(); stall = 1'b1; flush_lane = 2'(k + 1);
      drv_lane(0, 1, 1, 1, 1, 32'h999, 32'h999, 5'd31, 8'hFF, 2'd3, 2'd3);
      drv_lane(1, 1, 1, 1, 1, 32'h999, 32'h999, 5'd31, 8'hFF, 2'd3, 2'd3);
      exp_lane(0, 1, 0, 0, 1, 32'h33, 32'h0, 5'd6, 8'h20, 2'd0, 2'd0);
      exp_lane(1, 0, 0, 0, 1, 32'h44, 32'h55, 5'd9, 8'h21, 2'd1, 2'd2);
      issue(4, 1);
    end

    // 8: flush_all overrides stall
    start(); stall = 1'b1; flush_all = 1'b1;
    kill_lane(0, 32'h777, 5'd1);
    kill_lane(1, 32'h888, 5'd2);
    issue(4, 3);

    // 9: stall after flush holds zeros
    start(); stall = 1'b1;
    kill_lane(0, 32'h123, 5'd1);
    kill_lane(1, 32'h456, 5'd2);
    issue(4, 3);

    // 10: lane-1-only flush leaves lane0 store intact
    start(); flush_lane = 2'b10;
    pass_lane(0, 1, 0, 1, 0, 32'h40, 32'h0000_DEAD, 5'd2, 8'h30, 2'd0, 2'd0);
    kill_lane(1, 32'h41, 5'd8);
    issue(5, 4);

    // 11: lane1's own redirect does not kill lane1; lane0 flushed
    start(); flush_lane = 2'b01; branch_kill = 2'b10;
    kill_lane(0, 32'h50, 5'd10);
    pass_lane(1, 1, 1, 0, 1, 32'h51, 32'h0, 5'd11, 8'h41, 2'd1, 2'd0);
    issue(6, 5);

    // 12: youngest-lane redirect alone kills nothing
    start(); branch_kill = 2'b10;
    pass_lane(0, 1, 0, 0, 1, 32'h60, 32'h0, 5'd12, 8'h50, 2'd0, 2'd1);
    pass_lane(1, 1, 0, 0, 1, 32'h61, 32'h0, 5'd13, 8'h51, 2'd0, 2'd1);
    issue(8, 5);

    // 13-22: retired counter saturates at 15
    for (int k = 0; k < 10; k++) begin
      start();
      pass_lane(0, 1, 0, 0, 1, 32'h60, 32'h0, 5'd12, 8'h50, 2'd0, 2'd1);
      pass_lane(1, 1, 0, 0, 1, 32'h61, 32'h0, 5'd13, 8'h51, 2'd0, 2'd1);
      issue(ret_sat_tab[k], 5);
    end

    // 23-28: killed counter saturates through repeated flushes
    for (int k = 0; k < 6; k++) begin
      start(); flush_all = 1'b1;
      kill_lane(0, 32'h70, 5'd1);
      kill_lane(1, 32'h71, 5'd2);
      issue(15, kil_sat_tab[k]);
    end

    // 29: clear beats the same-cycle load increment
    start(); cnt_clr = 1'b1;
    pass_lane(0, 1, 1, 0, 1, 32'h80, 32'h0, 5'd14, 8'h60, 2'd1, 2'd0);
    pass_lane(1, 1, 0, 0, 0, 32'h81, 32'h0, 5'd15, 8'h61, 2'd0, 2'd0);
    issue(0, 0);

    // 30: counting resumes after clear
    start(); branch_kill = 2'b01;
    pass_lane(0, 1, 0, 0, 1, 32'h90, 32'h0, 5'd16, 8'h70, 2'd0, 2'd0);
    kill_lane(1, 32'h91, 5'd17);
    issue(1, 1);

    // 31: clear beats a flush_all increment
    start(); cnt_clr = 1'b1; flush_all = 1'b1;
    kill_lane(0, 32'hA0, 5'd1);
    kill_lane(1, 32'hA1, 5'd2);
    issue(0, 0);

    // 32: load lane0 then drop reset between edges
    start();
    pass_lane(0, 1, 0, 0, 1, 32'h1234, 32'h0, 5'd18, 8'h80, 2'd0, 2'd0);
    issue(1, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    e_next = '0;
    q_exp.push_back(e_next);
    q_id.push_back(next_id);
    next_id++;
    -> mid_ev;

    // 34: reset still low ignores a valid load
    start();
    drv_lane(0, 1, 1, 1, 1, 32'hCAFE, 32'h1, 5'd1, 8'h1, 2'd1, 2'd1);
    drv_lane(1, 1, 1, 1, 1, 32'hBEEF, 32'h1, 5'd1, 8'h1, 2'd1, 2'd1);
    issue(0, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    end_req = 1'b1;
    -> mid_ev;
  end

endmodule
`default_nettype wire
